// File: rtl/axi_pkg.sv
// Shared AXI read-channel constants and the read sequencer state type.
package axi_pkg;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] ARPORT_INSTR   = 3'b100;
  localparam logic [2:0] ARPORT_DATA    = 3'b000;
  localparam int         IFU_ID_DEF     = 0;
  localparam int         LSU_ID_DEF     = 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the pointer remembers the loser of the last grant.
module rr_arb2 (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  input  logic i_req_ifu,
  input  logic i_req_lsu,
  output logic o_gnt_ifu,
  output logic o_gnt_lsu
);
  logic r_ptr_lsu;
  logic w_pick_lsu;

  assign w_pick_lsu = i_req_lsu & (~i_req_ifu | r_ptr_lsu);
  assign o_gnt_lsu  = i_en & w_pick_lsu;
  assign o_gnt_ifu  = i_en & i_req_ifu & ~w_pick_lsu;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr_lsu <= 1'b1;
    end else if (o_gnt_ifu) begin
      r_ptr_lsu <= 1'b1;
    end else if (o_gnt_lsu) begin
      r_ptr_lsu <= 1'b0;
    end
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// IFU/LSU single-beat read arbiter driving one AXI AR/R pair, one transaction in flight.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int IFU_ID = IFU_ID_DEF,
  parameter int LSU_ID = LSU_ID_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ifu_req_valid,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_req_ready,
  input  logic              lsu_req_valid,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  output logic              lsu_req_ready,
  input  logic              ifu_flush,
  output logic              ifu_resp_valid,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARLOCK,
  output logic [3:0]        ARCACHE,
  output logic [2:0]        ARPORT,
  output logic [3:0]        ARQOS,
  output logic [3:0]        ARREGION,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output rd_state_e         dbg_state
);
  localparam logic [ID_W-1:0] W_IFU_ID = ID_W'(IFU_ID);
  localparam logic [ID_W-1:0] W_LSU_ID = ID_W'(LSU_ID);

  // Handshakes: a request transfers on the cycle req_valid && req_ready, the
  // address on ARVALID && ARREADY, and the data beat on RVALID && RREADY.
  rd_state_e         r_state;
  logic              r_owner_ifu;
  logic              r_drop;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [ID_W-1:0]   r_arid;
  logic [2:0]        r_arport;
  logic              r_ifu_rv;
  logic              r_lsu_rv;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;
  logic              w_idle;
  logic              w_gnt_ifu;
  logic              w_gnt_lsu;
  logic              w_unused;

  // Ready is gated by rstn so it drops together with everything else in reset.
  assign w_idle   = (r_state == IDLE) & rstn;
  assign w_unused = RRESP[0];

  rr_arb2 u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .i_en      (w_idle),
    .i_req_ifu (ifu_req_valid),
    .i_req_lsu (lsu_req_valid),
    .o_gnt_ifu (w_gnt_ifu),
    .o_gnt_lsu (w_gnt_lsu)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_owner_ifu <= 1'b0;
      r_drop      <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arid      <= '0;
      r_arport    <= '0;
      r_ifu_rv    <= 1'b0;
      r_lsu_rv    <= 1'b0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_ifu_rv <= 1'b0;
      r_lsu_rv <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_ifu || w_gnt_lsu) begin
            r_araddr    <= w_gnt_ifu ? ifu_req_addr : lsu_req_addr;
            r_arid      <= w_gnt_ifu ? W_IFU_ID : W_LSU_ID;
            r_arport    <= w_gnt_ifu ? ARPORT_INSTR : ARPORT_DATA;
            r_owner_ifu <= w_gnt_ifu;
            r_arvalid   <= 1'b1;
            r_state     <= ADDR;
          end
        end
        ADDR: begin
          if (r_owner_ifu && ifu_flush) r_drop <= 1'b1;
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (RVALID) begin
            r_resp_data <= RDATA;
            r_resp_err  <= RRESP[1] | (RID != r_arid) | ~RLAST;
            r_lsu_rv    <= ~r_owner_ifu;
            r_ifu_rv    <= r_owner_ifu & ~(r_drop | ifu_flush);
            r_drop      <= 1'b0;
            r_state     <= IDLE;
          end else if (r_owner_ifu && ifu_flush) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ifu_req_ready  = w_gnt_ifu;
  assign lsu_req_ready  = w_gnt_lsu;
  assign ifu_resp_valid = r_ifu_rv;
  assign lsu_resp_valid = r_lsu_rv;
  assign resp_data      = r_resp_data;
  assign resp_err       = r_resp_err;
  assign ARID           = r_arid;
  assign ARADDR         = r_araddr;
  assign ARPORT         = r_arport;
  assign ARVALID        = r_arvalid;
  assign ARLEN          = 8'd0;
  assign ARSIZE         = AXI_SIZE_8B;
  assign ARBURST        = AXI_BURST_INCR;
  assign ARLOCK         = 1'b0;
  assign ARCACHE        = 4'd0;
  assign ARQOS          = 4'd0;
  assign ARREGION       = 4'd0;
  assign RREADY         = (r_state == DATA);
  assign dbg_state      = r_state;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: grant order, latency, AR hold, flush, errors, async reset.
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ifu_req_valid, lsu_req_valid, ifu_flush;
  logic [63:0] ifu_req_addr, lsu_req_addr;
  logic        ifu_req_ready, lsu_req_ready;
  logic        ifu_resp_valid, lsu_resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic [3:0]  ARID;
  logic [63:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPORT;
  logic [3:0]  ARQOS;
  logic [3:0]  ARREGION;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  rd_state_e   dbg_state;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  axi_rd_arbiter dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_ready(lsu_req_ready),
    .ifu_flush(ifu_flush), .ifu_resp_valid(ifu_resp_valid), .lsu_resp_valid(lsu_resp_valid),
    .resp_data(resp_data), .resp_err(resp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPORT(ARPORT), .ARQOS(ARQOS), .ARREGION(ARREGION),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // Wait for a grant, check who won, then check the AR fields one cycle later.
  task automatic grant(input string tag, input logic exp_ifu);
    int n = 0;
    #1;
    while (!(ifu_req_ready || lsu_req_ready) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, {62'd0, ifu_req_ready, lsu_req_ready}, exp_ifu ? 64'd2 : 64'd1);
    tick();
    if (exp_ifu) ifu_req_valid = 1'b0;
    else         lsu_req_valid = 1'b0;
    RID = exp_ifu ? 4'd0 : 4'd1;
    chk({tag, "_arvalid"}, 64'(ARVALID), 64'd1);
    chk({tag, "_arid"}, 64'(ARID), exp_ifu ? 64'd0 : 64'd1);
    chk({tag, "_arport"}, 64'(ARPORT), exp_ifu ? 64'd4 : 64'd0);
  endtask

  task automatic wait_resp(input string tag, input logic exp_ifu, input logic exp_err,
                           input logic [63:0] exp_data);
    int n = 0;
    while (!(ifu_resp_valid || lsu_resp_valid) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rv"}, {62'd0, ifu_resp_valid, lsu_resp_valid}, exp_ifu ? 64'd2 : 64'd1);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_err"}, 64'(resp_err), 64'(exp_err));
  endtask

  initial begin
    rstn = 1'b0;
    ifu_req_valid = 0; lsu_req_valid = 0; ifu_flush = 0;
    ifu_req_addr = '0; lsu_req_addr = '0;
    ARREADY = 0; RID = 0; RDATA = '0; RRESP = 0; RLAST = 1; RVALID = 0;
    repeat (3) tick();
    chk("rst_ar", {54'd0, ARVALID, RREADY, ARID, ARPORT}, 64'd0);
    chk("rst_addr", ARADDR, 64'd0);
    chk("rst_resp", {61'd0, ifu_resp_valid, lsu_resp_valid, resp_err}, 64'd0);
    chk("rst_data", resp_data, 64'd0);
    chk("rst_rdy", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_const", {40'd0, ARLEN, 5'd0, ARSIZE, 2'd0, ARBURST, 3'd0, ARLOCK}, 64'h0000_0000_0000_0310);
    rstn = 1'b1;
    tick();

    // minimum latency IFU read
    ifu_req_valid = 1; ifu_req_addr = 64'h8000_0000;
    ARREADY = 1; RVALID = 1; RDATA = 64'h0000_0013_0000_0093; RRESP = 0; RLAST = 1;
    grant("t1", 1'b1);
    chk("t1_araddr", ARADDR, 64'h8000_0000);
    tick();
    chk("t1_c2", {62'd0, (dbg_state == DATA), RREADY}, 64'd3);
    tick();
    chk("t1_c3_rv", 64'(ifu_resp_valid), 64'd1);
    chk("t1_data", resp_data, 64'h0000_0013_0000_0093);
    chk("t1_err", 64'(resp_err), 64'd0);
    tick();
    chk("t1_c4_rv", 64'(ifu_resp_valid), 64'd0);
    RVALID = 0;

    // round-robin alternation from reset
    reset_dut();
    ifu_req_valid = 1; ifu_req_addr = 64'h3000;
    lsu_req_valid = 1; lsu_req_addr = 64'h2000;
    RVALID = 1; RDATA = 64'hA1;
    grant("t2a", 1'b0);
    wait_resp("t2a", 1'b0, 1'b0, 64'hA1);
    RDATA = 64'hA2;
    grant("t2b", 1'b1);
    ifu_req_valid = 1; lsu_req_valid = 1;
    wait_resp("t2b", 1'b1, 1'b0, 64'hA2);
    RDATA = 64'hA3;
    grant("t2c", 1'b0);
    wait_resp("t2c", 1'b0, 1'b0, 64'hA3);
    grant("t2d", 1'b1);
    wait_resp("t2d", 1'b1, 1'b0, 64'hA3);
    RVALID = 0;

    // ARREADY held low: AR stable, no accepts
    ARREADY = 0; RVALID = 1; RDATA = 64'hB1;
    ifu_req_valid = 1; ifu_req_addr = 64'h4000;
    grant("t3", 1'b1);
    lsu_req_valid = 1; lsu_req_addr = 64'h5000;
    for (int i = 0; i < 5; i++) begin
      chk("t3_arv", 64'(ARVALID), 64'd1);
      chk("t3_addr", ARADDR, 64'h4000);
      chk("t3_rdy", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      tick();
    end
    ARREADY = 1;
    wait_resp("t3", 1'b1, 1'b0, 64'hB1);
    RDATA = 64'hB2;
    grant("t3l", 1'b0);
    wait_resp("t3l", 1'b0, 1'b0, 64'hB2);
    tick();
    RVALID = 0;

    // flush while waiting for a delayed R beat
    ifu_req_valid = 1; ifu_req_addr = 64'h6000; RDATA = 64'hC1;
    grant("t4", 1'b1);
    tick();
    ifu_flush = 1; lsu_req_valid = 1; lsu_req_addr = 64'h7000;
    tick();
    ifu_flush = 0;
    tick();
    tick();
    tick();
    RVALID = 1;
    chk("t4_rready", 64'(RREADY), 64'd1);
    tick();
    RVALID = 0;
    chk("t4_rv", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    chk("t4_idle", 64'(dbg_state), 64'(IDLE));
    chk("t4_next", 64'(lsu_req_ready), 64'd1);
    RDATA = 64'hC2;
    grant("t4l", 1'b0);
    RVALID = 1;
    wait_resp("t4l", 1'b0, 1'b0, 64'hC2);
    RVALID = 0;
    tick();

    // flush on the completing beat
    ifu_req_valid = 1; ifu_req_addr = 64'h6100;
    grant("t4b", 1'b1);
    tick();
    RVALID = 1; ifu_flush = 1;
    tick();
    RVALID = 0; ifu_flush = 0;
    chk("t4b_rv", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    chk("t4b_idle", 64'(dbg_state), 64'(IDLE));

    // LSU error responses
    RVALID = 1; RRESP = 2'b10; RLAST = 1; RDATA = 64'hD1;
    lsu_req_valid = 1; lsu_req_addr = 64'h8008;
    grant("t5a", 1'b0);
    wait_resp("t5a", 1'b0, 1'b1, 64'hD1);
    tick();
    chk("t5a_once", 64'(lsu_resp_valid), 64'd0);
    RRESP = 2'b00; RLAST = 0; RDATA = 64'hD2;
    lsu_req_valid = 1;
    grant("t5b", 1'b0);
    wait_resp("t5b", 1'b0, 1'b1, 64'hD2);
    tick();
    chk("t5b_once", 64'(lsu_resp_valid), 64'd0);
    RLAST = 1; RVALID = 0;

    // async reset while in ADDR
    ARREADY = 0;
    ifu_req_valid = 1; ifu_req_addr = 64'h9000;
    grant("t6", 1'b1);
    ifu_req_valid = 1;
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_arv", 64'(ARVALID), 64'd0);
    chk("t6_state", 64'(dbg_state), 64'(IDLE));
    chk("t6_addr", ARADDR, 64'd0);
    chk("t6_rdy", 64'(ifu_req_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("t6_rel_rdy", 64'(ifu_req_ready), 64'd1);
    tick();
    chk("t6_rel_arv", 64'(ARVALID), 64'd1);
    chk("t6_rel_addr", ARADDR, 64'h9000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-requester read arbiter and sequencer for the core's single AXI read-address/read-data channel pair. The IFU (instruction fetch) and the LSU (data loads) issue single-beat 64-bit read requests. The arbiter grants one requester at a time, drives one AR transaction, collects the R beat and returns it to the owner. There is exactly one outstanding transaction. The block sits between the pipeline front end and load path and the top-level AR/R ports.

## Interface
Parameters:
- ADDR_W, 64, request/ARADDR width
- DATA_W, 64, RDATA/response width
- ID_W, 4, ARID/RID width
- IFU_ID, 0, ARID used for IFU transactions
- LSU_ID, 1, ARID used for LSU transactions

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset, asynchronous assert, active-low
- ifu_req_valid / lsu_req_valid  in  1  request pending; held until ready
- ifu_req_addr / lsu_req_addr  in  ADDR_W  read address, 8-byte aligned
- ifu_req_ready / lsu_req_ready  out  1  combinational accept strobe
- ifu_flush  in  1  discard any in-flight IFU response (pipeline jump)
- ifu_resp_valid / lsu_resp_valid  out  1  one-cycle response pulse
- resp_data  out  DATA_W  registered read data, shared by both requesters
- resp_err  out  1  registered error flag, qualified by resp_valid
- ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPORT, ARQOS, ARREGION, ARVALID  out  AXI AR channel
- ARREADY  in  1
- RID, RDATA, RRESP, RLAST, RVALID  in  AXI R channel
- RREADY  out  1

## Operation
- The FSM has three states: IDLE, ADDR, DATA. Reset state is IDLE.
- IDLE, with at least one request pending:
  - If only one requester is valid, it wins.
  - If both are valid, the round-robin pointer decides. The pointer holds the loser of the last grant, and its reset value favours the LSU.
  - req_ready for the winner is high in this cycle.
  - On the clock edge: ARADDR, ARID (owner ID) and ARPORT are latched, owner is stored, ARVALID<=1, and the state moves to ADDR.
- ADDR: ARVALID and the AR fields are held stable. On ARVALID&&ARREADY: ARVALID<=0 and the state moves to DATA.
- DATA: RREADY=1. The first beat with RVALID completes the transaction:
  - resp_data<=RDATA.
  - resp_err<=RRESP[1] | (RID!=owner ID) | !RLAST.
  - The owner's resp_valid pulses for the next cycle only.
  - The state returns to IDLE.
- Constant AR fields:
  - ARLEN=0, ARSIZE=3'b011, ARBURST=2'b01.
  - ARLOCK=0, ARCACHE=0, ARQOS=0, ARREGION=0.
  - ARPORT=3'b100 for IFU and 3'b000 for LSU (bit 2 = instruction access).
- Flush:
  - ifu_flush in any cycle while owner=IFU and the state is ADDR or DATA sets a sticky drop flag.
  - While the drop flag is set, the AXI transaction still completes normally, but ifu_resp_valid is suppressed.
  - The drop flag clears on return to IDLE.
  - ifu_flush in IDLE has no effect; the IFU withdraws its own request.
  - ifu_flush in the same cycle as the completing R beat also suppresses the response.
- LSU transactions are never flushed.

## Timing
- Reset values:
  - ARVALID=0, RREADY=0, ARADDR=0, ARID=0, ARPORT=0.
  - Both resp_valid=0, resp_data=0, resp_err=0.
  - Both req_ready=0, drop flag clear, RR pointer favouring the LSU.
- Minimum latency, with ARREADY and RVALID immediately high:
  - Accept at cycle 0, ARVALID high in cycle 1.
  - DATA state in cycle 2, with RVALID sampled.
  - resp_valid in cycle 3.
- Back-to-back: the FSM is in IDLE in the same cycle resp_valid is high, so the next accept can occur in that cycle. Sustained throughput is one transaction per 3 cycles.
- req_ready is never high outside IDLE and is never high for both requesters at once.
- RVALID in ADDR or IDLE is ignored (RREADY=0).
- Asserting rstn low mid-transaction forces all outputs to their reset values immediately. The lost transaction is not replayed.

## Structure
- Shared package axi_pkg holds:
  - AXI_SIZE_8B, AXI_BURST_INCR, ARPORT_INSTR, ARPORT_DATA.
  - The IFU_ID/LSU_ID defaults.
  - The rd_state_e enum (IDLE/ADDR/DATA).
- One sub-module, rr_arb2: a 2-way round-robin pick with a registered pointer, updated only on grant. The FSM, AR registers and response registers live in the top module.

## Test plan
- IFU only, addr 0x8000_0000, ARREADY=1, RDATA=0x0000_0013_0000_0093 with RVALID in the first DATA cycle → ARID=0, ARPORT=3'b100, ifu_resp_valid in cycle 3, resp_data matches, resp_err=0.
- Both request on the same cycle after reset → LSU granted first (ARID=1). The IFU is granted next. Both requests held again → LSU granted third (alternation).
- ARREADY held low 5 cycles → ARVALID/ARADDR stable for 5 cycles, no req_ready during that time; completion follows normally.
- IFU transaction in DATA with RVALID delayed 4 cycles, ifu_flush pulsed in cycle 2 → R beat accepted, ifu_resp_valid stays 0, next request accepted in the IDLE cycle.
- LSU read with RRESP=2'b10, then with RID=1 but RLAST=0 → resp_err=1 both times, lsu_resp_valid pulses once each.
- rstn low while in ADDR with ARVALID=1 → ARVALID=0 asynchronously, state IDLE. After release, a pending IFU request is accepted on the first clock.
